pc_fetch_seq: RTL

PC_FETCH_SEQ -- requirements
Module: pc_fetch_seq

---
 rtl/pc_fetch_seq_pkg.sv | 21 ++
 rtl/pc_fetch_seq_pc_reg.sv | 23 ++
 rtl/pc_fetch_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pc_fetch_seq_pkg.sv
// Shared fetch-sequencer definitions: state encoding, reset PC and PC increment.
package pc_fetch_seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StValid = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    // Jump keeps the region bits of the sequential successor of the jumping instruction.
    function automatic logic [31:0] jump_target(input logic [31:0] base_pc,
                                                input logic [25:0] index);
        logic [31:0] seq_pc;
        seq_pc = base_pc + PC_INC;
        return {seq_pc[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_seq_pc_reg.sv
// 32-bit program counter register with load enable.
module pc_reg
    import pc_fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // Hold the PC; reload only when the sequencer asks for it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_seq.sv
// Instruction fetch sequencer: issues one fetch at a time, holds the returned
// instruction for the consumer, and handles branch/jump redirects.
module pc_fetch_seq
    import pc_fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [25:0] jmp_index,
    output logic [31:0] pc
);

    fetch_state_e state_q, state_d;
    logic         pend_q, pend_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         pc_load;
    logic [31:0]  pc_d;
    logic         redir;
    logic [31:0]  redir_tgt;

    assign redir     = jmp | br_taken;
    assign redir_tgt = jmp ? jump_target(inst_pc_q, jmp_index) : {br_target[31:2], 2'b00};

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .d    (pc_d),
        .q    (pc)
    );

    // Next-state, pending redirect and held-instruction update.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        pc_load    = 1'b0;
        pc_d       = pc;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (imem_ack) begin
                    pend_d = 1'b0;
                    if (redir) begin
                        // A fresh redirect beats an older pending one.
                        pc_load = 1'b1;
                        pc_d    = redir_tgt;
                    end else if (pend_q) begin
                        pc_load = 1'b1;
                        pc_d    = pend_tgt_q;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc;
                        pc_load   = 1'b1;
                        pc_d      = pc + PC_INC;
                        state_d   = StValid;
                    end
                end else if (redir) begin
                    // Request must stay stable, so park the target until the ack.
                    pend_d     = 1'b1;
                    pend_tgt_d = redir_tgt;
                end
            end
            StValid: begin
                if (redir) begin
                    pc_load = 1'b1;
                    pc_d    = redir_tgt;
                    state_d = StFetch;
                end else if (!stall) begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, pending redirect and held instruction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0;
            inst_q     <= 32'h0;
            inst_pc_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
        end
    end

    // Outputs decode straight from state so reset drops the request at once.
    always_comb begin
        imem_req   = (state_q == StFetch);
        imem_addr  = pc;
        inst_valid = (state_q == StValid);
        inst       = inst_q;
        inst_pc    = inst_pc_q;
    end

endmodule
